// File: rtl/cgra0_conf_writer.sv
// Configuration writer: takes a session of commands and streams packed
// configuration words onto a registered bus shared by all PE conf readers.
module cgra0_conf_writer #(
  parameter int PE_COUNT     = 4,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] num_cmds,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_type,
  input  logic [15:0] cmd_pe_id,
  input  logic [3:0]  cmd_thread,
  input  logic [11:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic [63:0] conf_bus_out,
  output logic        busy,
  output logic        done,
  output logic [7:0]  err_count,
  output logic [1:0]  fsm_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready never depends on cmd_valid.

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;

  localparam int DW = $clog2(DRAIN_CYCLES + 2);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);
  localparam logic [16:0] PE_LIMIT = 17'(PE_COUNT);

  state_t          state, state_n;
  logic [15:0]     remaining;
  logic [DW-1:0]   drain_cnt;
  logic            accept;
  logic            cmd_ok;
  logic [63:0]     packed_word;

  assign cmd_ready = (state == SEND) && (remaining != 16'd0);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state == SEND) || (state == DRAIN);
  assign done      = (state == DONE);
  assign fsm_state = state;

  assign cmd_ok = (cmd_type != 8'd0) && (cmd_type <= 8'd7) &&
                  ({1'b0, cmd_pe_id} < PE_LIMIT);

  always_comb begin
    packed_word = 64'h0;
    case (cmd_type)
      8'd1:    packed_word = {8'h00, cmd_data[15:0], cmd_addr, cmd_thread, cmd_pe_id, cmd_type};
      8'd2:    packed_word = {cmd_data, cmd_addr[3:0], cmd_thread, cmd_pe_id, cmd_type};
      default: packed_word = {cmd_data, 4'h0, cmd_thread, cmd_pe_id, cmd_type};
    endcase
  end

  // DRAIN's first cycle carries the final word (or an empty slot when the
  // session had no commands), followed by DRAIN_CYCLES quiet cycles.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start) state_n = (num_cmds == 16'd0) ? DRAIN : SEND;
      SEND:  if (accept && remaining == 16'd1) state_n = DRAIN;
      DRAIN: if (drain_cnt == '0) state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      remaining    <= 16'd0;
      drain_cnt    <= '0;
      err_count    <= 8'd0;
      conf_bus_out <= 64'h0;
    end else begin
      state        <= state_n;
      conf_bus_out <= (accept && cmd_ok) ? packed_word : 64'h0;

      if (state == IDLE && start) begin
        remaining <= num_cmds;
        err_count <= 8'd0;
      end else if (accept) begin
        remaining <= remaining - 16'd1;
        if (!cmd_ok && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end

      if (state != DRAIN && state_n == DRAIN) drain_cnt <= DRAIN_LOAD;
      else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
    end
  end

endmodule
